// File: rtl/kevin_serial_detector_pkg.sv
// ---------------------------------------------------------------------------
// kevin_pkg
// Shared definitions for the Kevin-number serial detector: nibble width,
// Kevin-set membership mask, the collector FSM state type and the
// membership lookup helper.
// Kevin set = {1,5,6,7,9,10,12,14}; bit i of the mask set means value i hits.
// ---------------------------------------------------------------------------
package kevin_pkg;

    localparam int               NIBBLE_W       = 4;
    localparam logic [15:0]      KEVIN_SET_MASK = 16'h56E2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic is_kevin(input logic [NIBBLE_W-1:0] nibble);
        return KEVIN_SET_MASK[nibble];
    endfunction

endpackage

// File: rtl/kevin_serial_detector_nibble_match.sv
// ---------------------------------------------------------------------------
// kevin_nibble_match
// Purely combinational Kevin-set membership lookup on one nibble.
// Ports:
//   nibble  in   4  value to classify
//   match   out  1  1 when nibble is in the Kevin set
// ---------------------------------------------------------------------------
module kevin_nibble_match
    import kevin_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic                match
);

    assign match = is_kevin(nibble);

endmodule

// File: rtl/kevin_serial_detector.sv
// ---------------------------------------------------------------------------
// kevin_serial_detector
// Assembles a qualified serial bit stream into 4-bit nibbles (MSB-first by
// default), emits each completed nibble with a one-cycle valid pulse and its
// Kevin-set hit flag, and keeps a saturating count of hit nibbles.
//
// Ports:
//   clk           in   1      single clock, rising edge
//   rst           in   1      synchronous active-high reset
//   bit_in        in   1      serial data bit
//   bit_valid     in   1      bit_in is sampled on this edge when high
//   sync_clr      in   1      drop any partial nibble (frame resync)
//   nibble_out    out  4      last completed nibble
//   nibble_valid  out  1      one-cycle pulse when nibble_out/hit update
//   hit           out  1      nibble_out is in the Kevin set
//   busy          out  1      1 while 1-3 bits of a partial nibble are held
//   hit_count     out  CNT_W  saturating count of hit nibbles
//
// Build option:
//   KEVIN_LSB_FIRST_EN  when defined, bits are assembled LSB-first (first
//                       accepted bit lands in nibble_out[0]).
// ---------------------------------------------------------------------------
module kevin_serial_detector
    import kevin_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_in,
    input  logic                bit_valid,
    input  logic                sync_clr,
    output logic [NIBBLE_W-1:0] nibble_out,
    output logic                nibble_valid,
    output logic                hit,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state, state_nxt;
    logic [1:0]          bit_cnt, bit_cnt_nxt;
    logic [NIBBLE_W-1:0] sr, sr_nxt;
    logic                emit;
    logic                match;

    // Next-state / shift / emit decision
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sr_nxt      = sr;
        emit        = 1'b0;
        if (sync_clr) begin
            // Resync wins over a coincident bit, including a 4th bit.
            state_nxt   = IDLE;
            bit_cnt_nxt = 2'd0;
        end else if (bit_valid) begin
`ifdef KEVIN_LSB_FIRST_EN
            sr_nxt = {bit_in, sr[NIBBLE_W-1:1]};
`else
            sr_nxt = {sr[NIBBLE_W-2:0], bit_in};
`endif
            if (bit_cnt == 2'd3) begin
                emit        = 1'b1;
                state_nxt   = IDLE;
                bit_cnt_nxt = 2'd0;
            end else begin
                state_nxt   = COLLECT;
                bit_cnt_nxt = bit_cnt + 2'd1;
            end
        end
    end

    // Classify the value being emitted this edge.
    kevin_nibble_match u_match (
        .nibble (sr_nxt),
        .match  (match)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 2'd0;
            sr           <= '0;
            nibble_out   <= '0;
            nibble_valid <= 1'b0;
            hit          <= 1'b0;
            hit_count    <= '0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sr           <= sr_nxt;
            nibble_valid <= emit;
            if (emit) begin
                nibble_out <= sr_nxt;
                hit        <= match;
                if (match && (hit_count != CNT_MAX))
                    hit_count <= hit_count + 1'b1;
            end
        end
    end

    // State is a register, so busy is registered as well.
    assign busy = (state == COLLECT);

endmodule
